// File: rtl/syn_trap_ctrl_pkg.sv
// rtl/syn_trap_ctrl_pkg.sv - shared QR decoder constants and state encoding
// Purpose: state encoding for the error-trapping FSM, default code constants.
// Ports: none (package).
package syn_trap_ctrl_pkg;

  // Weight-check stage is fixed at this syndrome width.
  localparam int SYN_W_DEF  = 36;
  localparam int NSHIFT_DEF = 72;
  localparam int CNT_W_DEF  = 7;

  // Generator coefficients below the implicit x^36 term: x^36 + x^3 + 1.
  localparam logic [SYN_W_DEF-1:0] GPOLY_DEF = 36'h0_0000_0009;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } trap_state_t;

endpackage

// File: rtl/syn_trap_ctrl_lfsr_step.sv
// rtl/syn_trap_ctrl_lfsr_step.sv - one combinational step x*s(x) mod g(x)
// Purpose: single generator-LFSR step used by the trap scan.
// Ports:
//   syn      in  SYN_W  current syndrome
//   syn_next out SYN_W  syndrome multiplied by x, reduced mod g(x)
module syn_lfsr_step
  import syn_trap_ctrl_pkg::*;
#(
  parameter int               SYN_W = SYN_W_DEF,
  parameter logic [SYN_W-1:0] GPOLY = SYN_W'(GPOLY_DEF)
) (
  input  logic [SYN_W-1:0] syn,
  output logic [SYN_W-1:0] syn_next
);

  // The bit shifted out of the top stands for x^SYN_W, which reduces to GPOLY.
  assign syn_next = {syn[SYN_W-2:0], 1'b0} ^ (syn[SYN_W-1] ? GPOLY : '0);

endmodule

// File: rtl/syn_trap_ctrl.sv
// rtl/syn_trap_ctrl.sv - sequential error-trapping controller for the QR decoder
// Purpose: load a syndrome, step it through the generator LFSR one step per
//   cycle, and latch the first pattern the external weight check flags.
// Ports:
//   clk          in  1      system clock, rising edge
//   rst_n        in  1      asynchronous active-low reset
//   start_i      in  1      load syn_i and begin a trap (only while ready_o)
//   abort_i      in  1      synchronous abort back to IDLE, no done pulse
//   syn_i        in  SYN_W  initial syndrome
//   syn_o        out SYN_W  current LFSR value, feeds the weight check
//   weight_flag  in  1      weight check response to syn_o, same cycle
//   ready_o      out 1      high in IDLE and DONE
//   busy_o       out 1      high in SCAN
//   done_o       out 1      one-cycle result pulse
//   found_o      out 1      1 = trapped, 0 = uncorrectable; held
//   err_pat_o    out SYN_W  trapped pattern; held
//   shift_cnt_o  out CNT_W  step index of the trap; held
module syn_trap_ctrl
  import syn_trap_ctrl_pkg::*;
#(
  parameter int               SYN_W  = SYN_W_DEF,
  parameter logic [SYN_W-1:0] GPOLY  = SYN_W'(GPOLY_DEF),
  parameter int               NSHIFT = NSHIFT_DEF,
  parameter int               CNT_W  = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic [SYN_W-1:0] syn_i,
  output logic [SYN_W-1:0] syn_o,
  input  logic             weight_flag,
  output logic             ready_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             found_o,
  output logic [SYN_W-1:0] err_pat_o,
  output logic [CNT_W-1:0] shift_cnt_o
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NSHIFT - 1);

  trap_state_t      state_q, state_d;
  logic [SYN_W-1:0] syn_q, syn_d, syn_step;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             found_q, found_d;
  logic [SYN_W-1:0] err_q, err_d;
  logic [CNT_W-1:0] sc_q, sc_d;

  syn_lfsr_step #(
    .SYN_W (SYN_W),
    .GPOLY (GPOLY)
  ) u_step (
    .syn      (syn_q),
    .syn_next (syn_step)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      syn_q   <= '0;
      cnt_q   <= '0;
      found_q <= 1'b0;
      err_q   <= '0;
      sc_q    <= '0;
    end else begin
      state_q <= state_d;
      syn_q   <= syn_d;
      cnt_q   <= cnt_d;
      found_q <= found_d;
      err_q   <= err_d;
      sc_q    <= sc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    syn_d   = syn_q;
    cnt_d   = cnt_q;
    found_d = found_q;
    err_d   = err_q;
    sc_d    = sc_q;

    // Abort outranks start and the weight flag; held results stay untouched.
    if (abort_i) begin
      state_d = ST_IDLE;
      syn_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            state_d = ST_SCAN;
            syn_d   = syn_i;
            cnt_d   = '0;
          end
        end
        ST_SCAN: begin
          if (weight_flag) begin
            state_d = ST_DONE;
            found_d = 1'b1;
            err_d   = syn_q;
            sc_d    = cnt_q;
          end else if (cnt_q == LAST_CNT) begin
            state_d = ST_DONE;
            found_d = 1'b0;
            err_d   = '0;
            sc_d    = LAST_CNT;
          end else begin
            syn_d = syn_step;
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_DONE: begin
          // Back-to-back start reloads straight into SCAN with no IDLE cycle.
          if (start_i) begin
            state_d = ST_SCAN;
            syn_d   = syn_i;
            cnt_d   = '0;
          end else begin
            state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign syn_o       = syn_q;
  assign ready_o     = (state_q == ST_IDLE) || (state_q == ST_DONE);
  assign busy_o      = (state_q == ST_SCAN);
  assign done_o      = (state_q == ST_DONE);
  assign found_o     = found_q;
  assign err_pat_o   = err_q;
  assign shift_cnt_o = sc_q;

endmodule

// File: tb/tb_syn_trap_ctrl.sv
// tb/tb_syn_trap_ctrl.sv - directed self-checking bench for syn_trap_ctrl
module tb_syn_trap_ctrl;

  localparam int SYN_W  = 36;
  localparam int CNT_W  = 7;
  localparam int NSHIFT = 72;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start_i = 1'b0;
  logic             abort_i = 1'b0;
  logic [SYN_W-1:0] syn_i = '0;
  logic [SYN_W-1:0] syn_o;
  logic             weight_flag;
  logic             ready_o, busy_o, done_o, found_o;
  logic [SYN_W-1:0] err_pat_o;
  logic [CNT_W-1:0] shift_cnt_o;

  logic use_model = 1'b1;
  logic flag_force = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;

  // Weight check model: flag when at most four bits are set.
  assign weight_flag = use_model ? ($countones(syn_o) <= 4) : flag_force;

  always #5 clk = ~clk;

  syn_trap_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_i     (start_i),
    .abort_i     (abort_i),
    .syn_i       (syn_i),
    .syn_o       (syn_o),
    .weight_flag (weight_flag),
    .ready_o     (ready_o),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .found_o     (found_o),
    .err_pat_o   (err_pat_o),
    .shift_cnt_o (shift_cnt_o)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int edges;
    int busy_cnt;
    logic [SYN_W-1:0] s36, s37;

    // Reset state
    #12;
    chk("rst_ready", ready_o, 1);
    chk("rst_busy", busy_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_found", found_o, 0);
    chk("rst_err", err_pat_o, 0);
    chk("rst_sc", shift_cnt_o, 0);
    chk("rst_syn", syn_o, 0);
    tick;
    rst_n = 1'b1;
    tick;

    // A: weight-4 syndrome traps at k=0
    use_model = 1'b1;
    syn_i = 36'h0_0000_000F;
    start_i = 1'b1;
    tick;
    start_i = 1'b0;
    chk("a_syn0", syn_o, 36'h0_0000_000F);
    chk("a_busy", busy_o, 1);
    chk("a_done_early", done_o, 0);
    tick;
    chk("a_done", done_o, 1);
    chk("a_found", found_o, 1);
    chk("a_err", err_pat_o, 36'h0_0000_000F);
    chk("a_sc", shift_cnt_o, 0);
    tick;
    chk("a_done_pulse", done_o, 0);
    chk("a_idle_ready", ready_o, 1);

    // Failure: flag held low, syn=1, scan runs to NSHIFT
    use_model = 1'b0;
    flag_force = 1'b0;
    syn_i = 36'h1;
    start_i = 1'b1;
    tick;
    start_i = 1'b0;
    edges = 1;
    busy_cnt = 0;
    s36 = '0;
    s37 = '0;
    while (!done_o && edges < 200) begin
      if (busy_o) busy_cnt++;
      if (edges == 36) s36 = syn_o;
      if (edges == 37) s37 = syn_o;
      tick;
      edges++;
    end
    chk("f_latency", edges, NSHIFT + 1);
    chk("f_scan_cycles", busy_cnt, NSHIFT);
    chk("f_x35", s36, 36'h8_0000_0000);
    chk("f_x36_wrap", s37, 36'h0_0000_0009);
    chk("f_found", found_o, 0);
    chk("f_sc", shift_cnt_o, 71);
    chk("f_err", err_pat_o, 0);
    tick;

    // B: weight-5 syndrome, first step folds to weight-4 0x17
    use_model = 1'b1;
    syn_i = 36'h8_0000_000F;
    start_i = 1'b1;
    tick;
    start_i = 1'b0;
    chk("b_syn0", syn_o, 36'h8_0000_000F);
    tick;
    chk("b_syn1", syn_o, 36'h0_0000_0017);
    chk("b_not_done", done_o, 0);
    tick;
    chk("b_done", done_o, 1);
    chk("b_found", found_o, 1);
    chk("b_err", err_pat_o, 36'h0_0000_0017);
    chk("b_sc", shift_cnt_o, 1);
    tick;

    // Ignored mid-scan start, then abort at step 5
    use_model = 1'b0;
    flag_force = 1'b0;
    syn_i = 36'h1;
    start_i = 1'b1;
    tick;
    start_i = 1'b0;
    tick;
    tick;
    syn_i = 36'h0_0000_0ABC;
    start_i = 1'b1;
    tick;
    start_i = 1'b0;
    chk("ign_start_syn3", syn_o, 36'h8);
    chk("ign_start_busy", busy_o, 1);
    tick;
    tick;
    chk("abt_syn5", syn_o, 36'h20);
    abort_i = 1'b1;
    flag_force = 1'b1;
    tick;
    abort_i = 1'b0;
    flag_force = 1'b0;
    chk("abt_idle", ready_o, 1);
    chk("abt_busy", busy_o, 0);
    chk("abt_no_done", done_o, 0);
    chk("abt_syn_clr", syn_o, 0);
    chk("abt_found_held", found_o, 1);
    chk("abt_err_held", err_pat_o, 36'h0_0000_0017);
    chk("abt_sc_held", shift_cnt_o, 1);
    tick;
    chk("abt_no_done2", done_o, 0);

    // Back-to-back start in the DONE cycle
    use_model = 1'b1;
    syn_i = 36'h0_0000_000F;
    start_i = 1'b1;
    tick;
    start_i = 1'b0;
    tick;
    chk("bb1_done", done_o, 1);
    chk("bb1_err", err_pat_o, 36'h0_0000_000F);
    syn_i = 36'h8_0000_000F;
    start_i = 1'b1;
    tick;
    start_i = 1'b0;
    chk("bb2_no_idle", busy_o, 1);
    chk("bb2_reload", syn_o, 36'h8_0000_000F);
    chk("bb2_err_kept", err_pat_o, 36'h0_0000_000F);
    chk("bb2_sc_kept", shift_cnt_o, 0);
    tick;
    chk("bb2_err_kept2", err_pat_o, 36'h0_0000_000F);
    tick;
    chk("bb2_done", done_o, 1);
    chk("bb2_err", err_pat_o, 36'h0_0000_0017);
    chk("bb2_sc", shift_cnt_o, 1);
    tick;

    // Asynchronous reset mid-scan
    use_model = 1'b0;
    flag_force = 1'b0;
    syn_i = 36'h0_0000_0123;
    start_i = 1'b1;
    tick;
    start_i = 1'b0;
    tick;
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_busy", busy_o, 0);
    chk("arst_ready", ready_o, 1);
    chk("arst_done", done_o, 0);
    chk("arst_syn", syn_o, 0);
    chk("arst_found", found_o, 0);
    chk("arst_err", err_pat_o, 0);
    chk("arst_sc", shift_cnt_o, 0);
    tick;
    rst_n = 1'b1;
    tick;
    chk("arst_no_done", done_o, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
